// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: column count, FSM states, key map.
package keypad_scanner_pkg;

  localparam int unsigned NUM_COLS = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Pmod KYPD legend indexed [row][col]
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key/entry outputs of the scanner.
interface keypad_scanner_if;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic        Clr;
  logic [3:0]  KeyCode;
  logic        KeyStrobe;
  logic        KeyDown;
  logic [15:0] Value;

  modport master (
    input  Row, Clr,
    output Col, KeyCode, KeyStrobe, KeyDown, Value
  );

  modport slave (
    output Row, Clr,
    input  Col, KeyCode, KeyStrobe, KeyDown, Value
  );
endinterface

// File: rtl/kp_debounce.sv
// Frame-level debouncer: a frame result must repeat DEBOUNCE_FRAMES times to be stable.
module kp_debounce #(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end,
  input  logic       frame_hit,
  input  logic [3:0] frame_code,
  output logic       stable,
  output logic       stable_hit,
  output logic [3:0] stable_code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [CNT_W-1:0] count;
  logic             prev_hit;
  logic [3:0]       prev_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      prev_hit  <= 1'b0;
      prev_code <= '0;
    end else if (frame_end) begin
      if ({frame_hit, frame_code} == {prev_hit, prev_code}) begin
        if (count != CNT_MAX) count <= count + CNT_W'(1);
      end else begin
        count     <= CNT_W'(1);
        prev_hit  <= frame_hit;
        prev_code <= frame_code;
      end
    end
  end

  assign stable      = (count == CNT_MAX);
  assign stable_hit  = prev_hit;
  assign stable_code = prev_code;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, frame decode, press/release FSM
// and a 16-bit hex entry register.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned       SCAN_W    = $clog2(SCAN_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [1:0]        COL_LAST  = 2'(NUM_COLS - 1);

  logic [3:0]        row_s1, row_s2;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        col_idx;
  logic              sample;
  logic [1:0]        low_cnt;
  logic [3:0]        acc_code;
  logic [2:0]        col_lows, lows_sum;
  logic [1:0]        low_row;
  logic [3:0]        code_now;
  logic              frame_end, frame_hit;
  logic [3:0]        frame_code;
  logic              stable, stable_hit;
  logic [3:0]        stable_code;
  state_t            state_q, state_d;
  logic              accept;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= kp.Row;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      scan_cnt <= '0;
      col_idx  <= '0;
    end else if (sample) begin
      scan_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Rows are read on the last clock of a column period so they have settled
  assign sample = (scan_cnt == SCAN_LAST);

  always_comb kp.Col = ~(4'b0001 << col_idx);

  always_comb begin
    col_lows = '0;
    low_row  = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_lows = col_lows + 3'd1;
        low_row  = 2'(r);
      end
    end
    lows_sum   = {1'b0, low_cnt} + col_lows;
    code_now   = (low_cnt == 2'd0 && col_lows == 3'd1) ? key_map(low_row, col_idx) : acc_code;
    frame_end  = sample && (col_idx == COL_LAST);
    frame_hit  = (lows_sum == 3'd1);
    frame_code = frame_hit ? code_now : '0;
  end

  // Low-bit count saturates at 2: anything beyond one low row is a miss
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      low_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      if (frame_end) begin
        low_cnt  <= '0;
        acc_code <= '0;
      end else begin
        low_cnt  <= (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        acc_code <= code_now;
      end
    end
  end

  kp_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (Clk),
    .rst_n      (Rst),
    .frame_end  (frame_end),
    .frame_hit  (frame_hit),
    .frame_code (frame_code),
    .stable     (stable),
    .stable_hit (stable_hit),
    .stable_code(stable_code)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stable && stable_hit) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (stable && !stable_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Value commits on the clock where KeyStrobe is high, so a Clr on that
  // same clock yields just the new digit
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      kp.KeyStrobe <= 1'b0;
      kp.KeyCode   <= '0;
      kp.Value     <= '0;
    end else begin
      kp.KeyStrobe <= accept;
      if (accept) kp.KeyCode <= stable_code;
      if (kp.KeyStrobe) begin
        kp.Value <= kp.Clr ? {12'h000, kp.KeyCode} : {kp.Value[11:0], kp.KeyCode};
      end else if (kp.Clr) begin
        kp.Value <= '0;
      end
    end
  end

  assign kp.KeyDown = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model that pulls rows from the driven column.
module tb_keypad_scanner;

  logic        Clk;
  logic        Rst;
  logic [15:0] keys;
  int          passes  = 0;
  int          total   = 0;
  int          strobes = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_CYCLES    (8),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .kp (kp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // keys bit r*4+c pulls row r low while column c is driven low
  always_comb begin
    kp.Row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.Col[c]) kp.Row[r] = 1'b0;
  end

  always @(negedge Clk) if (kp.KeyStrobe === 1'b1) strobes++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_rotation(input string tag);
    check({tag, " c0"}, 16'(kp.Col), 16'hE);
    repeat (8) @(negedge Clk);
    check({tag, " c1"}, 16'(kp.Col), 16'hD);
    repeat (8) @(negedge Clk);
    check({tag, " c2"}, 16'(kp.Col), 16'hB);
    repeat (8) @(negedge Clk);
    check({tag, " c3"}, 16'(kp.Col), 16'h7);
    repeat (8) @(negedge Clk);
    check({tag, " wrap"}, 16'(kp.Col), 16'hE);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 96 && kp.KeyDown !== 1'b0; i++) @(negedge Clk);
    check({tag, " release"}, 16'(kp.KeyDown), 16'h0);
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code,
                       input logic [15:0] exp_val, input bit clr_on_strobe, input string tag);
    int s0;
    bit seen;
    s0   = strobes;
    seen = 1'b0;
    keys = '0;
    keys[r*4+c] = 1'b1;
    for (int i = 0; i < 96 && !seen; i++) begin
      @(negedge Clk);
      if (kp.KeyStrobe === 1'b1) begin
        seen = 1'b1;
        if (clr_on_strobe) kp.Clr = 1'b1;
      end
    end
    check({tag, " strobe"}, 16'(seen), 16'h1);
    @(negedge Clk);
    kp.Clr = 1'b0;
    check({tag, " code"}, 16'(kp.KeyCode), 16'(code));
    check({tag, " down"}, 16'(kp.KeyDown), 16'h1);
    check({tag, " value"}, kp.Value, exp_val);
    repeat (96) @(negedge Clk);
    keys = '0;
    wait_release(tag);
    repeat (8) @(negedge Clk);
    check({tag, " count"}, 16'(strobes - s0), 16'h1);
  endtask

  initial begin
    int         s0;
    bit         found;
    bit         seen;
    logic [3:0] prev;
    int         x;

    Rst    = 1'b0;
    kp.Clr = 1'b0;
    keys   = '0;
    #1;
    check("rst col", 16'(kp.Col), 16'hE);
    check("rst value", kp.Value, 16'h0);
    check("rst strobe", 16'(kp.KeyStrobe), 16'h0);
    check("rst down", 16'(kp.KeyDown), 16'h0);
    check("rst code", 16'(kp.KeyCode), 16'h0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    check_rotation("rot");

    press(1, 1, 4'h5, 16'h0005, 1'b0, "key5");

    press(0, 0, 4'h1, 16'h0051, 1'b0, "key1");
    press(0, 1, 4'h2, 16'h0512, 1'b0, "key2");
    press(0, 2, 4'h3, 16'h5123, 1'b0, "key3");
    press(1, 0, 4'h4, 16'h1234, 1'b0, "key4");
    press(3, 3, 4'hD, 16'h234D, 1'b0, "keyD");

    // Bounce on '1' (r0,c0), phased against the column-0 sample point so no
    // two consecutive frames see the same bounce level
    found = 1'b0;
    prev  = kp.Col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge Clk);
      if (prev == 4'h7 && kp.Col == 4'hE) found = 1'b1;
      prev = kp.Col;
    end
    check("bounce align", 16'(found), 16'h1);
    s0 = strobes;
    for (int m = 0; m < 420; m++) begin
      x    = m - 3;
      keys = '0;
      if (x >= 0 && (x >= 200 || ((x / 10) % 2) == 0)) keys[0] = 1'b1;
      if (m == 240) check("bounce quiet", 16'(strobes - s0), 16'h0);
      @(negedge Clk);
    end
    check("bounce count", 16'(strobes - s0), 16'h1);
    check("bounce code", 16'(kp.KeyCode), 16'h1);
    check("bounce down", 16'(kp.KeyDown), 16'h1);
    check("bounce value", kp.Value, 16'h34D1);
    keys = '0;
    wait_release("bounce");

    // 'A' and 'B' share column 3: two low rows is a miss
    s0 = strobes;
    keys = '0;
    keys[0*4+3] = 1'b1;
    keys[1*4+3] = 1'b1;
    repeat (160) @(negedge Clk);
    check("ghost none", 16'(strobes - s0), 16'h0);
    check("ghost down", 16'(kp.KeyDown), 16'h0);
    keys = '0;
    repeat (96) @(negedge Clk);

    // Hold 'A'; 'C' joins for under one column-3 revisit, so at most one frame misses
    s0   = strobes;
    seen = 1'b0;
    keys = '0;
    keys[0*4+3] = 1'b1;
    for (int i = 0; i < 96 && !seen; i++) begin
      @(negedge Clk);
      if (kp.KeyStrobe === 1'b1) seen = 1'b1;
    end
    check("holdA strobe", 16'(seen), 16'h1);
    @(negedge Clk);
    check("holdA code", 16'(kp.KeyCode), 16'hA);
    check("holdA value", kp.Value, 16'h4D1A);
    repeat (40) @(negedge Clk);
    keys[2*4+3] = 1'b1;
    repeat (20) @(negedge Clk);
    keys[2*4+3] = 1'b0;
    repeat (128) @(negedge Clk);
    check("holdA count", 16'(strobes - s0), 16'h1);
    check("holdA down", 16'(kp.KeyDown), 16'h1);
    keys = '0;
    wait_release("holdA");

    press(0, 0, 4'h1, 16'hD1A1, 1'b0, "re1");
    press(0, 1, 4'h2, 16'h1A12, 1'b0, "re2");
    press(0, 2, 4'h3, 16'hA123, 1'b0, "re3");
    press(1, 0, 4'h4, 16'h1234, 1'b0, "re4");
    kp.Clr = 1'b1;
    @(negedge Clk);
    kp.Clr = 1'b0;
    check("clr value", kp.Value, 16'h0000);
    press(2, 2, 4'h9, 16'h0009, 1'b0, "key9");
    press(2, 0, 4'h7, 16'h0007, 1'b1, "clr7");

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge Clk);
      if (kp.Col == 4'hB) found = 1'b1;
    end
    check("midscan col2", 16'(found), 16'h1);
    Rst = 1'b0;
    #1;
    check("midrst col", 16'(kp.Col), 16'hE);
    check("midrst value", kp.Value, 16'h0);
    check("midrst strobe", 16'(kp.KeyStrobe), 16'h0);
    check("midrst code", 16'(kp.KeyCode), 16'h0);
    @(negedge Clk);
    Rst = 1'b1;
    check_rotation("rot2");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
